// File: rtl/fxp_arith_unit.sv
// fxp_arith_unit
//   Multi-cycle unsigned Q(WIDTH-FBITS).FBITS arithmetic unit: add, subtract,
//   multiply and square root behind a start/busy/done handshake.
//   Multiply walks one HALF x HALF multiplier over four partial products;
//   square root is a restoring engine producing one root bit per cycle.
//
//   Build option: define FXP_SAT_EN to saturate overflowing results
//   (ADD/MUL -> all-ones, SUB borrow -> zero). The overflow flag is reported
//   either way and latency is identical.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; aborts any op, clears state
//   start      in   request strobe, sampled only while busy=0
//   operation  in   2'b00 ADD, 2'b01 SUB, 2'b10 MUL, 2'b11 SQRT
//   operand_1  in   first operand (radicand for SQRT)
//   operand_2  in   second operand (ignored for SQRT)
//   result     out  registered result, held until the next completion
//   done       out  one-cycle pulse when result/overflow are updated
//   busy       out  high while an op is in flight
//   overflow   out  carry/borrow/high-product flag, held with result
module fxp_arith_unit #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  localparam int HALF  = WIDTH / 2;
  localparam int ITER  = (WIDTH + FBITS) / 2;
  localparam int RADW  = WIDTH + FBITS;
  // Remainder never exceeds 2*root, so ITER+2 bits hold it with margin.
  localparam int REMW  = ITER + 2;
  localparam int CNT_W = ($clog2(ITER + 1) > 3) ? $clog2(ITER + 1) : 3;

`ifdef FXP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [1:0] FPU_ADD  = 2'b00;
  localparam logic [1:0] FPU_SUB  = 2'b01;
  localparam logic [1:0] FPU_MUL  = 2'b10;
  localparam logic [1:0] FPU_SQRT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDSUB, S_MUL, S_SQRT} state_t;

  function automatic logic [WIDTH-1:0] sat_high(input logic [WIDTH-1:0] v,
                                                input logic ovf);
    return (SAT_EN && ovf) ? {WIDTH{1'b1}} : v;
  endfunction

  function automatic logic [WIDTH-1:0] sat_low(input logic [WIDTH-1:0] v,
                                               input logic ovf);
    return (SAT_EN && ovf) ? {WIDTH{1'b0}} : v;
  endfunction

  state_t               state_q, state_d;
  logic                 sub_q, sub_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [RADW-1:0]      rad_q, rad_d;
  logic [REMW-1:0]      rem_q, rem_d;
  logic [ITER-1:0]      root_q, root_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum, diff;
  logic [HALF-1:0]      mul_a, mul_b;
  logic [WIDTH-1:0]     prod;
  logic [2*WIDTH-1:0]   pp;
  logic [REMW+1:0]      rem_shift, trial;
  logic                 fits;
  logic                 mul_ovf;

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign mul_ovf = |acc_q[2*WIDTH-1:WIDTH+FBITS];

  // Partial-product selection: cnt bit0 picks the a half, bit1 the b half,
  // and the shift is HALF per high half involved.
  always_comb begin
    mul_a = cnt_q[0] ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
    mul_b = cnt_q[1] ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
    prod  = {{HALF{1'b0}}, mul_a} * {{HALF{1'b0}}, mul_b};
    pp    = {{WIDTH{1'b0}}, prod};
    case (cnt_q[1:0])
      2'd0:       pp = pp;
      2'd1, 2'd2: pp = pp << HALF;
      default:    pp = pp << WIDTH;
    endcase
  end

  // Restoring square-root step: bring down the next radicand bit pair and
  // try subtracting (root<<2)|1.
  assign rem_shift = {rem_q, rad_q[RADW-1:RADW-2]};
  assign trial     = {{(REMW-ITER){1'b0}}, root_q, 2'b01};
  assign fits      = (rem_shift >= trial);

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = operand_1;
          b_d    = operand_2;
          sub_d  = operation[0];
          cnt_d  = '0;
          acc_d  = '0;
          rad_d  = RADW'(operand_1) << FBITS;
          rem_d  = '0;
          root_d = '0;
          case (operation)
            FPU_ADD, FPU_SUB: state_d = S_ADDSUB;
            FPU_MUL:          state_d = S_MUL;
            FPU_SQRT:         state_d = S_SQRT;
            default:          state_d = S_IDLE;
          endcase
        end
      end

      S_ADDSUB: begin
        if (sub_q) begin
          res_d = sat_low(diff[WIDTH-1:0], diff[WIDTH]);
          ovf_d = diff[WIDTH];
        end else begin
          res_d = sat_high(sum[WIDTH-1:0], sum[WIDTH]);
          ovf_d = sum[WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_MUL: begin
        if (cnt_q == CNT_W'(4)) begin
          res_d   = sat_high(acc_q[WIDTH+FBITS-1:FBITS], mul_ovf);
          ovf_d   = mul_ovf;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_q + pp;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SQRT: begin
        if (cnt_q == CNT_W'(ITER)) begin
          res_d   = WIDTH'(root_q);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rem_d  = fits ? (rem_shift[REMW-1:0] - trial[REMW-1:0])
                        : rem_shift[REMW-1:0];
          root_d = {root_q[ITER-2:0], fits};
          rad_d  = rad_q << 2;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign result   = res_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fxp_arith_unit.sv
module tb_fxp_arith_unit;
  localparam int W = 32;
  localparam int F = 10;

`ifdef FXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   operation = 2'b00;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fxp_arith_unit #(.WIDTH(W), .FBITS(F)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand_1(operand_1), .operand_2(operand_2),
    .result(result), .done(done), .busy(busy), .overflow(overflow)
  );

  // Reference model: plain wide-integer arithmetic on the fixed-point values.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic o, output int lat);
    longint unsigned full, x, s;
    case (op)
      2'd0: begin
        full = {32'd0, a} + {32'd0, b};
        o = (full >= 64'h1_0000_0000);
        r = full[31:0];
        if (SAT && o) r = 32'hFFFF_FFFF;
        lat = 1;
      end
      2'd1: begin
        o = (a < b);
        r = a - b;
        if (SAT && o) r = 32'd0;
        lat = 1;
      end
      2'd2: begin
        full = {32'd0, a} * {32'd0, b};
        x = full >> F;
        r = x[31:0];
        o = ((full >> (W + F)) != 0);
        if (SAT && o) r = 32'hFFFF_FFFF;
        lat = 5;
      end
      default: begin
        x = {32'd0, a} << F;
        s = longint'($floor($sqrt(real'(x))));
        while (s * s > x) s = s - 1;
        while ((s + 1) * (s + 1) <= x) s = s + 1;
        r = s[31:0];
        o = 1'b0;
        lat = (W + F) / 2 + 1;
      end
    endcase
  endfunction

  // Issue one op and wait (bounded) for done; operands are scrambled after E0.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic o, output int lat,
                       output logic busy_ok);
    @(negedge clk);
    operation = op; operand_1 = a; operand_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom; operation = 2'($urandom);
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (lat > 0 && busy !== 1'b0) busy_ok = 1'b0;
    r = result;
    o = overflow;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got=%h exp=%h", result, 32'd0); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
    logic [31:0] as  [8] = '{32'h0000_0C00, 32'h0000_0A00, 32'hFFFF_FFFF, 32'h0000_1000,
                             32'h0000_0800, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFFF};
    logic [31:0] bs  [8] = '{32'h0000_0600, 32'h0000_0600, 32'h0000_0800, 32'h0,
                             32'h0, 32'h0, 32'h0000_0200, 32'h0000_0001};
    logic [31:0] er  [8] = '{32'h0000_1200, 32'h0000_0F00, 32'hFFFF_FFFE, 32'h0000_0800,
                             32'h0000_05A8, 32'h0, 32'hFFFF_FF00, 32'h0};
    logic [31:0] ers [8] = '{32'h0000_1200, 32'h0000_0F00, 32'hFFFF_FFFF, 32'h0000_0800,
                             32'h0000_05A8, 32'h0, 32'h0, 32'hFFFF_FFFF};
    logic        eo  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int          el  [8] = '{1, 5, 5, 22, 22, 22, 1, 1};
    logic [31:0] r, exp_r;
    logic        o, bok;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], r, o, lat, bok);
      exp_r = SAT ? ers[i] : er[i];
      tests++; if (r !== exp_r) begin fails++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, exp_r); end
      tests++; if (o !== eo[i]) begin fails++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, o, eo[i]); end
      tests++; if (lat !== el[i]) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
      tests++; if (bok !== 1'b1) begin fails++; $display("FAIL dir%0d_busy got=%b exp=1", i, bok); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, r, er;
    logic        o, eo, bok;
    int          lat, el;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h000F_FFFF) : $urandom;
      b = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h000F_FFFF) : $urandom;
      ref_model(op, a, b, er, eo, el);
      do_op(op, a, b, r, o, lat, bok);
      tests++; if (r !== er || o !== eo) begin fails++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h/%b exp=%h/%b", i, op, a, b, r, o, er, eo); end
      tests++; if (lat !== el) begin fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, el); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] r, er;
    logic        o, eo, bok;
    int          lat, el;
    ref_model(2'd2, 32'h0012_3456, 32'h0000_4321, er, eo, el);
    do_op(2'd2, 32'h0012_3456, 32'h0000_4321, r, o, lat, bok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); operand_1 = $urandom; operand_2 = $urandom; operation = 2'($urandom);
      @(posedge clk); #1;
      tests++; if (result !== er || overflow !== eo || done !== 1'b0) begin fails++; $display("FAIL hold%0d got=%h/%b done=%b exp=%h/%b done=0", i, result, overflow, done, er, eo); end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    operation = 2'd3; operand_1 = 32'h0000_0800; operand_2 = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
      if (i == 3) begin start = 1'b1; operation = 2'd0; operand_1 = 32'h0000_0C00; operand_2 = 32'h0000_0600; end
      if (i == 4) start = 1'b0;
    end
    tests++; if (result !== 32'h0000_05A8) begin fails++; $display("FAIL ignore_start_result got=%h exp=%h", result, 32'h0000_05A8); end
    tests++; if (lat !== 22) begin fails++; $display("FAIL ignore_start_latency got=%0d exp=22", lat); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL ignore_start_idle busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    operation = 2'd0; operand_1 = 32'h0000_0C00; operand_2 = 32'h0000_0600; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || result !== 32'h0000_1200) begin fails++; $display("FAIL b2b_add done=%b result=%h exp 1/%h", done, result, 32'h0000_1200); end
    start = 1'b1; operation = 2'd2; operand_1 = 32'h0000_0A00; operand_2 = 32'h0000_0600;
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_accept busy=%b done=%b exp 1/0", busy, done); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
    tests++; if (lat !== 5 || result !== 32'h0000_0F00) begin fails++; $display("FAIL b2b_mul lat=%0d result=%h exp 5/%h", lat, result, 32'h0000_0F00); end
  endtask

  task automatic test_reset_mid();
    int          dones;
    logic [31:0] r, er;
    logic        o, eo, bok;
    int          lat, el;
    @(negedge clk);
    operation = 2'd3; operand_1 = 32'h0000_1000; operand_2 = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || overflow !== 1'b0) begin fails++; $display("FAIL reset_mid busy=%b done=%b result=%h ovf=%b exp 0/0/0/0", busy, done, result, overflow); end
    @(negedge clk); reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL reset_mid_no_done got=%0d exp=0", dones); end
    ref_model(2'd2, 32'h0000_0A00, 32'h0000_0600, er, eo, el);
    do_op(2'd2, 32'h0000_0A00, 32'h0000_0600, r, o, lat, bok);
    tests++; if (r !== er || o !== eo || lat !== el) begin fails++; $display("FAIL reset_mid_mul got=%h/%b lat=%0d exp=%h/%b lat=%0d", r, o, lat, er, eo, el); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fxp_arith_unit.md
Name: fxp_arith_unit

Overview:
- Multi-cycle, parametrised successor to the combinational fixed-point unit: unsigned Q(WIDTH-FBITS).FBITS add, sub, multiply and square root behind a start/busy/done handshake.
- Multiply reuses a single HALF x HALF multiplier over four partial-product cycles. Square root is an iterative restoring bit-pair engine.
- Sits beside the integer ALU in the execute stage; the core stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be even.
- FBITS, 10, fractional bits; WIDTH+FBITS must be even.
- HALF, WIDTH/2, multiplier slice width (derived localparam).
- ITER, (WIDTH+FBITS)/2, square-root iterations (derived localparam).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  request strobe; sampled only when busy=0
- operation  in  2  FPU_ADD=00, FPU_SUB=01, FPU_MUL=10, FPU_SQRT=11 (Defines.vh codes)
- operand_1  in  WIDTH  first operand (radicand for SQRT)
- operand_2  in  WIDTH  second operand (ignored for SQRT)
- result  out  WIDTH  registered result; held until next accepted op completes
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high while an op is in flight
- overflow  out  1  valid with done; held with result

Behaviour:
- Reset (async, any time, including mid-op): state=IDLE; result=0, done=0, busy=0, overflow=0; accumulators and counters cleared. No done is produced for the aborted op.
- States: IDLE, ADDSUB, MUL, SQRT.
- Edge numbering: E0 is the edge sampling start=1 with busy=0. At E0, operands and operation are latched, busy goes to 1, and the state moves to the op state.
- start with busy=1 is ignored, with no effect on the in-flight op.
- ADDSUB: result and done are registered at E1.
  - ADD: overflow = carry-out.
  - SUB: overflow = borrow (operand_1 < operand_2).
  - Result wraps modulo 2^WIDTH.
- MUL: partial products are accumulated into a 2*WIDTH accumulator, one per edge, using the single HALF x HALF multiplier:
  - E1: a_lo*b_lo
  - E2: a_hi*b_lo << HALF
  - E3: a_lo*b_hi << HALF
  - E4: a_hi*b_hi << WIDTH
  - E5: result = acc[WIDTH+FBITS-1:FBITS]; overflow = |acc[2*WIDTH-1:WIDTH+FBITS]; done=1.
- SQRT: computes floor(sqrt(operand_1 << FBITS)), using a (WIDTH+FBITS)-bit radicand.
  - One root bit per edge, E1..E_ITER (restoring: remainder = remainder<<2 | next bit pair; trial = root<<2|1).
  - E_ITER+1: result = zero-extended root; overflow=0; done=1.
  - Defaults give latency 22.
- done is high for exactly one cycle. At the edge done rises, busy falls and the state returns to IDLE.
- A start in the done cycle is accepted; that edge is E0 of the next op, giving back-to-back throughput.
- Operands may change after E0 without effect.
- result and overflow change only at a completion edge or on reset.

Optional Feature:
- FXP_SAT_EN defined: overflow results saturate.
  - ADD and MUL overflow → all-ones.
  - SUB borrow → 0.
  - overflow flag still reported.
  - Latency unchanged.
- FXP_SAT_EN undefined: wrap/truncate as described in Behaviour.

Test Plan:
- ADD 0x00000C00 + 0x00000600 → result 0x00001200, overflow=0, done at E1, busy high only E0→E1.
- MUL 0x00000A00 × 0x00000600 → 0x00000F00 at E5, overflow=0. Then 0xFFFFFFFF × 0x00000800 → 0xFFFFFFFE, overflow=1 (with FXP_SAT_EN: 0xFFFFFFFF).
- SQRT 0x00001000 → 0x00000800; SQRT 0x00000800 → 0x000005A8; done at E22 for defaults. SQRT 0 → 0.
- SUB 0x00000100 − 0x00000200 → 0xFFFFFF00, overflow=1 (with FXP_SAT_EN: 0x00000000).
- Start pulsed during SQRT busy with ADD operands → ignored; SQRT result unaffected. Start held high in the done cycle → next op accepted at that edge.
- Assert reset at E10 of SQRT → immediately busy=0, done=0, result=0. No done afterwards. Next MUL completes normally.
